sr_ff_driver: RTL and testbench

- Write-side controller for a bank of WIDTH external SR flip-flops; the flops' storage side is the counterpart of this block.
- Accepts masked write requests over a valid/ready handshake and converts each target value into per-bit S/R commands using the SR excitation table. It never drives S=R=1.
- After each write it reads back the flop Q outputs, reports mismatches on a response handshake, and counts them.
- Sits between register-style control logic and any SR storage bank built from the team's SR flop.

---
 rtl/sr_pkg.sv | 20 ++
 rtl/sr_excite.sv | 32 +++
 rtl/sr_ff_driver.sv | 122 ++++++++++++
 tb/tb_sr_ff_driver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and {s,r} command encodings for the SR flop write-side driver.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sr_drv_state_t;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_RESET = 2'b01;
  localparam logic [1:0] SR_SET   = 2'b10;

  // Command that moves a flop to target; S and R are never both requested.
  function automatic logic [1:0] sr_toward(input logic target);
    return target ? SR_SET : SR_RESET;
  endfunction

endpackage

// File: rtl/sr_excite.sv
// Per-bit SR excitation: minimal commands for trusted bits, forced commands otherwise.
module sr_excite
  import sr_pkg::*;
(
  input  logic target,
  input  logic shadow,
  input  logic known,
  input  logic mask,
  output logic s,
  output logic r
);

  logic [1:0] code_s;

  // Select the {s,r} command for this bit.
  always_comb begin
    code_s = SR_HOLD;
    if (!mask) begin
      code_s = SR_HOLD;
    end else if (!known) begin
      code_s = sr_toward(target);
    end else if (target != shadow) begin
      code_s = sr_toward(target);
    end else begin
      code_s = SR_HOLD;
    end
  end

  assign s = code_s[1];
  assign r = code_s[0];

endmodule

// File: rtl/sr_ff_driver.sv
// Write-side controller for a bank of SR flops: masked writes, readback check,
// mismatch reporting over a response handshake and a saturating error count.
module sr_ff_driver
  import sr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_mismatch,
  output logic [ERRW-1:0]  err_count,
  output logic             busy
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  sr_drv_state_t    state_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] shadow_r;
  logic [WIDTH-1:0] known_r;
  logic [3:0]       cnt_r;
  logic [WIDTH-1:0] s_next_s;
  logic [WIDTH-1:0] r_next_s;
  logic [WIDTH-1:0] mismatch_s;

  // Commands are computed from the incoming request so the pulse is registered
  // on the accepting edge and appears during the DRIVE cycle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    sr_excite u_excite (
      .target (req_data[i]),
      .shadow (shadow_r[i]),
      .known  (known_r[i]),
      .mask   (req_mask[i]),
      .s      (s_next_s[i]),
      .r      (r_next_s[i])
    );
  end

  assign mismatch_s = (q_in ^ shadow_r) & known_r;
  assign req_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);

  // Handshake FSM, drive pulse, settle counter and readback bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      data_r        <= '0;
      mask_r        <= '0;
      shadow_r      <= '0;
      known_r       <= '0;
      cnt_r         <= 4'd0;
      s_out         <= '0;
      r_out         <= '0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_mismatch <= '0;
      err_count     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            data_r  <= req_data;
            mask_r  <= req_mask;
            s_out   <= s_next_s;
            r_out   <= r_next_s;
            state_r <= DRIVE;
          end
        end
        DRIVE: begin
          s_out    <= '0;
          r_out    <= '0;
          shadow_r <= (shadow_r & ~mask_r) | (data_r & mask_r);
          known_r  <= known_r | mask_r;
          cnt_r    <= CNT_LOAD;
          state_r  <= WAIT;
        end
        WAIT: begin
          s_out <= '0;
          r_out <= '0;
          if (cnt_r == 4'd0) begin
            resp_mismatch <= mismatch_s;
            resp_err      <= |mismatch_s;
            known_r       <= known_r & ~mismatch_s;
            if ((|mismatch_s) && (err_count != {ERRW{1'b1}})) begin
              err_count <= err_count + ERRW'(1);
            end
            resp_valid <= 1'b1;
            state_r    <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          s_out      <= '0;
          r_out      <= '0;
          resp_valid <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ff_driver.sv
// Randomized self-checking bench for sr_ff_driver with a behavioural SR flop bank
// and a vector-level reference model of shadow/known/error state.
module tb_sr_ff_driver;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, default SETTLE
  logic         rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_err, busy;
  logic [W-1:0] req_data, req_mask, s_out, r_out, resp_mismatch, err_count;
  logic [W-1:0] q_flop = '0, stuck0 = '0, stuck1 = '0;

  sr_ff_driver #(.WIDTH(W), .SETTLE(1), .ERRW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask), .s_out(s_out), .r_out(r_out),
    .q_in(q_flop), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_err(resp_err), .resp_mismatch(resp_mismatch), .err_count(err_count),
    .busy(busy)
  );

  // Second DUT with a longer settle time for the mid-WAIT reset scenario
  logic         rst4_n, v4, rr4, rv4, rdy4, re4, busy4;
  logic [W-1:0] d4, m4, s4, r4, rm4, ec4;
  logic [W-1:0] q4 = '0;

  sr_ff_driver #(.WIDTH(W), .SETTLE(4), .ERRW(8)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .req_valid(v4), .req_ready(rr4),
    .req_data(d4), .req_mask(m4), .s_out(s4), .r_out(r4),
    .q_in(q4), .resp_valid(rv4), .resp_ready(rdy4),
    .resp_err(re4), .resp_mismatch(rm4), .err_count(ec4), .busy(busy4)
  );

  // External SR flops with optional stuck-at faults.
  always @(posedge clk) begin
    q_flop <= (((q_flop & ~r_out) | s_out) & ~stuck0) | stuck1;
    q4     <= (q4 & ~r4) | s4;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    check_val("sr_exclusive", 32'(s_out & r_out), 32'h0);
    check_val("sr_exclusive4", 32'(s4 & r4), 32'h0);
  end

  // Reference model state
  logic [W-1:0] m_shadow = '0;
  logic [W-1:0] m_known  = '0;
  int           m_errs   = 0;

  task automatic do_write(input logic [W-1:0] data, input logic [W-1:0] mask,
                          input int hold, input bit pre_ready);
    logic [W-1:0] need, exp_s, exp_r, exp_mis;
    int n;
    @(negedge clk);
    check_val("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid  = 1'b1;
    req_data   = data;
    req_mask   = mask;
    resp_ready = pre_ready;
    need  = mask & (~m_known | (m_shadow ^ data));
    exp_s = need & data;
    exp_r = need & ~data;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_val("drive_s", 32'(s_out), 32'(exp_s));
    check_val("drive_r", 32'(r_out), 32'(exp_r));
    check_val("drive_busy", 32'(busy), 32'h1);
    check_val("drive_req_ready", 32'(req_ready), 32'h0);
    m_shadow = (m_shadow & ~mask) | (data & mask);
    m_known  = m_known | mask;
    n = 1;
    while (!resp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check_val("resp_latency", 32'(n), 32'd3);
    exp_mis = (q_flop ^ m_shadow) & m_known;
    m_known = m_known & ~exp_mis;
    if (exp_mis != '0 && m_errs < 255) m_errs++;
    check_val("resp_err", 32'(resp_err), 32'(|exp_mis));
    check_val("resp_mismatch", 32'(resp_mismatch), 32'(exp_mis));
    check_val("err_count", 32'(err_count), 32'(m_errs));
    if (!pre_ready) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        check_val("bp_valid", 32'(resp_valid), 32'h1);
        check_val("bp_mismatch", 32'(resp_mismatch), 32'(exp_mis));
        check_val("bp_req_ready", 32'(req_ready), 32'h0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_val("ret_valid", 32'(resp_valid), 32'h0);
    check_val("ret_busy", 32'(busy), 32'h0);
    check_val("ret_req_ready", 32'(req_ready), 32'h1);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; rst4_n = 1'b0;
    req_valid = 1'b0; req_data = '0; req_mask = '0; resp_ready = 1'b0;
    v4 = 1'b0; d4 = '0; m4 = '0; rdy4 = 1'b0;
    #12;
    check_val("rst_s", 32'(s_out), 32'h0);
    check_val("rst_r", 32'(r_out), 32'h0);
    check_val("rst_valid", 32'(resp_valid), 32'h0);
    check_val("rst_err", 32'(resp_err), 32'h0);
    check_val("rst_mismatch", 32'(resp_mismatch), 32'h0);
    check_val("rst_count", 32'(err_count), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; rst4_n = 1'b1;

    // Directed sequence from the plan
    do_write(8'hA5, 8'hFF, 0, 1'b0);
    check_val("flops_a5", 32'(q_flop), 32'hA5);
    do_write(8'hA4, 8'hFF, 0, 1'b0);
    do_write(8'hA4, 8'hFF, 0, 1'b1);
    do_write(8'hFF, 8'h0F, 0, 1'b0);
    check_val("flops_af", 32'(q_flop), 32'hAF);
    stuck0 = 8'h08;
    do_write(8'h08, 8'h08, 0, 1'b0);
    check_val("fault_mismatch", 32'(resp_mismatch), 32'h08);
    check_val("fault_count", 32'(err_count), 32'h1);
    do_write(8'h08, 8'h08, 5, 1'b0);
    stuck0 = 8'h00;
    do_write(8'h00, 8'h00, 0, 1'b1);

    // Random writes with occasional stuck-at faults
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      stuck0 = '0; stuck1 = '0;
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) stuck0 = 8'(1 << $urandom_range(7));
        else stuck1 = 8'(1 << $urandom_range(7));
      end
      do_write(8'($urandom), 8'($urandom), int'($urandom_range(3)), 1'($urandom_range(1)));
    end
    @(negedge clk);
    stuck1 = '0;
    stuck0 = 8'h01;

    // Saturation of the error counter
    for (int t = 0; t < 300; t++) do_write(8'h01, 8'h01, 0, 1'b1);
    check_val("err_saturate", 32'(err_count), 32'd255);
    @(negedge clk);
    stuck0 = '0;

    // Reset during WAIT on the SETTLE=4 instance
    @(negedge clk);
    v4 = 1'b1; d4 = 8'h3C; m4 = 8'hFF;
    @(posedge clk);
    #1 v4 = 1'b0;
    check_val("d4_first_s", 32'(s4), 32'h3C);
    check_val("d4_first_r", 32'(r4), 32'hC3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("d4_in_wait", 32'(busy4), 32'h1);
    #2 rst4_n = 1'b0;
    #1;
    check_val("d4_rst_s", 32'(s4), 32'h0);
    check_val("d4_rst_r", 32'(r4), 32'h0);
    check_val("d4_rst_valid", 32'(rv4), 32'h0);
    check_val("d4_rst_err", 32'(re4), 32'h0);
    check_val("d4_rst_mis", 32'(rm4), 32'h0);
    check_val("d4_rst_count", 32'(ec4), 32'h0);
    check_val("d4_rst_busy", 32'(busy4), 32'h0);
    @(negedge clk);
    rst4_n = 1'b1;
    #1;
    check_val("d4_req_ready", 32'(rr4), 32'h1);
    @(negedge clk);
    v4 = 1'b1; d4 = 8'h5A; m4 = 8'h0F;
    @(posedge clk);
    #1 v4 = 1'b0;
    check_val("d4_forced_s", 32'(s4), 32'h0A);
    check_val("d4_forced_r", 32'(r4), 32'h05);
    n = 1;
    while (!rv4 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check_val("d4_latency", 32'(n), 32'd6);
    check_val("d4_resp_err", 32'(re4), 32'h0);
    @(negedge clk);
    rdy4 = 1'b1;
    @(posedge clk);
    #1;
    check_val("d4_ret_valid", 32'(rv4), 32'h0);
    check_val("d4_ret_ready", 32'(rr4), 32'h1);
    rdy4 = 1'b0;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
